// File: rtl/lucas_pkg.sv
// Shared types and default sizes for the second-order recurrence engine.
// Optional build macro: LUCAS_SAT_EN (saturating adder, see lucas_add_sat).
package lucas_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} lucas_state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_N_WIDTH = 16;

endpackage

// File: rtl/lucas_add_sat.sv
// Combinational adder for the recurrence step, returning the sum and its carry-out.
// Build macro LUCAS_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module lucas_add_sat
    import lucas_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[WIDTH];

`ifdef LUCAS_SAT_EN
    // Once clamped, the operand stays all-ones, so every later term saturates too.
    assign o_sum = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
    assign o_sum = w_full[WIDTH-1:0];
`endif

endmodule

// File: rtl/lucas_seq_engine.sv
// Programmable-seed x[k] = x[k-1] + x[k-2] engine with done/ack handshake, abort and sticky overflow.
// Build macro LUCAS_SAT_EN: saturating arithmetic (selected inside lucas_add_sat).
module lucas_seq_engine
    import lucas_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_WIDTH = DEF_N_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    input  logic [WIDTH-1:0]   seed0,
    input  logic [WIDTH-1:0]   seed1,
    input  logic               abort,
    input  logic               done_ack,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout,
    output logic               ovf
);

    localparam logic [N_WIDTH-1:0] CNT_ONE = N_WIDTH'(1);

    lucas_state_e       r_state;
    logic [WIDTH-1:0]   r_f0;
    logic [WIDTH-1:0]   r_f1;
    logic [N_WIDTH-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_dout;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;

    lucas_add_sat #(.WIDTH(WIDTH)) u_add (
        .i_a     (r_f0),
        .i_b     (r_f1),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_f0    <= '0;
            r_f1    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (n == '0) begin
                            r_dout  <= seed0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (n == CNT_ONE) begin
                            r_dout  <= seed1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_f0    <= seed0;
                            r_f1    <= seed1;
                            r_cnt   <= n - CNT_ONE;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // abort outranks completion on the same edge; dout is left untouched
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end else begin
                        r_f0  <= r_f1;
                        r_f1  <= w_sum;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_cnt == CNT_ONE) begin
                            r_dout  <= w_sum;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end else if (done_ack) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dout = r_dout;
    assign ovf  = r_ovf;

endmodule
